trace_emitter: RTL

- In-design retire-trace source that generates the architectural event stream the processor bench otherwise scrapes hierarchically.
- Samples writeback, memory and cache events from the pipeline each cycle and packs them into fixed 36-bit records (REG/LOAD/STORE/HALT/STAT).
- Buffers records in a small FIFO and emits them over a valid/ready port to a trace sink.
- On halt, appends a HALT record plus summary statistics records, then signals done.

---
 rtl/trace_pkg.sv | 44 ++++
 rtl/trace_emitter_if.sv | 12 +
 rtl/trace_fifo.sv | 58 +++++
 rtl/trace_emitter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared definitions for the retire-trace emitter: record layout, record type
// codes, STAT record indices and the control FSM state type.
package trace_pkg;

    localparam int TYPE_W   = 4;
    localparam int TAG_W    = 16;
    localparam int VAL_W    = 16;
    localparam int VAL_LSB  = 0;
    localparam int TAG_LSB  = VAL_LSB + VAL_W;
    localparam int TYPE_LSB = TAG_LSB + TAG_W;
    localparam int REC_W    = TYPE_LSB + TYPE_W;

    localparam logic [TYPE_W-1:0] REC_REG   = 4'd1;
    localparam logic [TYPE_W-1:0] REC_LOAD  = 4'd2;
    localparam logic [TYPE_W-1:0] REC_STORE = 4'd3;
    localparam logic [TYPE_W-1:0] REC_HALT  = 4'd4;
    localparam logic [TYPE_W-1:0] REC_STAT  = 4'd5;

    localparam logic [2:0] STAT_CYCLES = 3'd0;
    localparam logic [2:0] STAT_INST   = 3'd1;
    localparam logic [2:0] STAT_DHIT   = 3'd2;
    localparam logic [2:0] STAT_IHIT   = 3'd3;
    localparam logic [2:0] STAT_DREQ   = 3'd4;
    localparam logic [2:0] STAT_IREQ   = 3'd5;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HALT,
        ST_STAT,
        ST_DONE
    } state_t;

    function automatic logic [REC_W-1:0] pack_rec(input logic [TYPE_W-1:0] rtype,
                                                  input logic [TAG_W-1:0]  tag,
                                                  input logic [VAL_W-1:0]  value);
        logic [REC_W-1:0] rec;
        rec = '0;
        rec[TYPE_LSB +: TYPE_W] = rtype;
        rec[TAG_LSB +: TAG_W]   = tag;
        rec[VAL_LSB +: VAL_W]   = value;
        return rec;
    endfunction

endpackage

// File: rtl/trace_emitter_if.sv
// Record stream from the trace emitter to a trace sink (valid/ready).
interface trace_emitter_if;
    import trace_pkg::*;

    logic             rec_valid;
    logic             rec_ready;
    logic [REC_W-1:0] rec_data;

    modport master (output rec_valid, output rec_data, input rec_ready);
    modport slave  (input rec_valid, input rec_data, output rec_ready);

endinterface

// File: rtl/trace_fifo.sv
// Record FIFO: DEPTH x REC_W entries, up to three pushes and one pop per cycle.
// The caller guarantees push_n never exceeds the free slot count.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [1:0]                      push_n,
    input  logic [2:0][REC_W-1:0]           push_rec,
    input  logic                            pop,
    output logic [REC_W-1:0]                head,
    output logic [$clog2(DEPTH):0]          count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    logic [REC_W-1:0] mem_q [DEPTH];
    logic [REC_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             pop_ok;

    assign pop_ok = pop && (count_q != '0);

    // Records land at consecutive slots starting at the write pointer.
    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < 3; i++) begin
            if (2'(i) < push_n) begin
                mem_d[wr_ptr_q + PTR_W'(i)] = push_rec[i];
            end
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(push_n);
        rd_ptr_d = pop_ok ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push_n) - CW'(pop_ok);
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/trace_emitter.sv
// Retire-trace source: packs pipeline events into 36-bit records and streams them out.
// Define TRACE_EMITTER_STATS_EN to add statistic counters and the STAT record phase.
module trace_emitter
    import trace_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16,
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_we,
    input  logic [2:0]        reg_sel,
    input  logic [15:0]       reg_data,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [15:0]       mem_addr,
    input  logic [15:0]       mem_rdata,
    input  logic [15:0]       mem_wdata,
    input  logic              halt,
    input  logic              icache_req,
    input  logic              icache_hit,
    input  logic              dcache_req,
    input  logic              dcache_hit,
    trace_emitter_if.master   rec_if,
    output logic              trace_stall,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              done
);

    localparam int CW = $clog2(DEPTH) + 1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && !(&v)) ? v + CNT_W'(1) : v;
    endfunction

    state_t                 state_q, state_d;
    logic [DROP_W-1:0]      drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0]       cycle_cnt_q, cycle_cnt_d;
    logic [1:0]             push_n;
    logic [1:0]             slot;
    logic [2:0][REC_W-1:0]  push_rec;
    logic [REC_W-1:0]       fifo_head;
    logic [CW-1:0]          fifo_count;
    logic [CW-1:0]          free;
    logic                   full;
    logic                   run;
    logic                   pop;

    assign free = CW'(DEPTH) - fifo_count;
    assign full = (fifo_count == CW'(DEPTH));
    assign run  = (state_q == ST_RUN);
    assign pop  = rec_if.rec_valid && rec_if.rec_ready;

`ifdef TRACE_EMITTER_STATS_EN
    logic [CNT_W-1:0] inst_cnt_q, inst_cnt_d;
    logic [CNT_W-1:0] ihit_cnt_q, ihit_cnt_d;
    logic [CNT_W-1:0] ireq_cnt_q, ireq_cnt_d;
    logic [CNT_W-1:0] dhit_cnt_q, dhit_cnt_d;
    logic [CNT_W-1:0] dreq_cnt_q, dreq_cnt_d;
    logic [2:0]       stat_idx_q, stat_idx_d;
    logic [CNT_W-1:0] stat_val;

    always_comb begin
        inst_cnt_d = sat_inc(inst_cnt_q, run && (halt || reg_we || mem_wr));
        ihit_cnt_d = sat_inc(ihit_cnt_q, run && icache_hit);
        ireq_cnt_d = sat_inc(ireq_cnt_q, run && icache_req);
        dhit_cnt_d = sat_inc(dhit_cnt_q, run && dcache_hit);
        dreq_cnt_d = sat_inc(dreq_cnt_q, run && dcache_req);
    end

    always_comb begin
        stat_val = '0;
        unique case (stat_idx_q)
            STAT_CYCLES: stat_val = cycle_cnt_q;
            STAT_INST:   stat_val = inst_cnt_q;
            STAT_DHIT:   stat_val = dhit_cnt_q;
            STAT_IHIT:   stat_val = ihit_cnt_q;
            STAT_DREQ:   stat_val = dreq_cnt_q;
            STAT_IREQ:   stat_val = ireq_cnt_q;
            default:     stat_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inst_cnt_q <= '0;
            ihit_cnt_q <= '0;
            ireq_cnt_q <= '0;
            dhit_cnt_q <= '0;
            dreq_cnt_q <= '0;
            stat_idx_q <= '0;
        end else begin
            inst_cnt_q <= inst_cnt_d;
            ihit_cnt_q <= ihit_cnt_d;
            ireq_cnt_q <= ireq_cnt_d;
            dhit_cnt_q <= dhit_cnt_d;
            dreq_cnt_q <= dreq_cnt_d;
            stat_idx_q <= stat_idx_d;
        end
    end
`else
    logic unused_stat_inputs;
    assign unused_stat_inputs = ^{icache_req, icache_hit, dcache_req, dcache_hit};
`endif

    // A RUN cycle's events are pushed all together or, if they do not fit, not at all.
    always_comb begin
        state_d     = state_q;
        drop_cnt_d  = drop_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        push_n      = 2'd0;
        push_rec    = '0;
        slot        = 2'd0;
`ifdef TRACE_EMITTER_STATS_EN
        stat_idx_d  = stat_idx_q;
`endif
        unique case (state_q)
            ST_RUN: begin
                cycle_cnt_d = sat_inc(cycle_cnt_q, 1'b1);
                if (reg_we) begin
                    push_rec[slot] = pack_rec(REC_REG, TAG_W'(reg_sel), reg_data);
                    slot = slot + 2'd1;
                end
                if (mem_rd) begin
                    push_rec[slot] = pack_rec(REC_LOAD, mem_addr, mem_rdata);
                    slot = slot + 2'd1;
                end
                if (mem_wr) begin
                    push_rec[slot] = pack_rec(REC_STORE, mem_addr, mem_wdata);
                    slot = slot + 2'd1;
                end
                if (free >= CW'(slot)) begin
                    push_n = slot;
                end else if (!(&drop_cnt_q)) begin
                    drop_cnt_d = drop_cnt_q + DROP_W'(1);
                end
                if (halt) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (!full) begin
                    push_n      = 2'd1;
                    push_rec[0] = pack_rec(REC_HALT, '0, VAL_W'(cycle_cnt_q));
`ifdef TRACE_EMITTER_STATS_EN
                    state_d     = ST_STAT;
`else
                    state_d     = ST_DONE;
`endif
                end
            end
            ST_STAT: begin
`ifdef TRACE_EMITTER_STATS_EN
                if (!full) begin
                    push_n      = 2'd1;
                    push_rec[0] = pack_rec(REC_STAT, TAG_W'(stat_idx_q), VAL_W'(stat_val));
                    if (stat_idx_q == STAT_IREQ) begin
                        state_d = ST_DONE;
                    end else begin
                        stat_idx_d = stat_idx_q + 3'd1;
                    end
                end
`else
                state_d = ST_DONE;
`endif
            end
            ST_DONE: begin
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            drop_cnt_q  <= '0;
            cycle_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drop_cnt_q  <= drop_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_n   (push_n),
        .push_rec (push_rec),
        .pop      (pop),
        .head     (fifo_head),
        .count    (fifo_count)
    );

    assign rec_if.rec_valid = (fifo_count != '0);
    assign rec_if.rec_data  = fifo_head;
    assign trace_stall      = run && (free < CW'(3));
    assign drop_cnt         = drop_cnt_q;
    assign done             = (state_q == ST_DONE) && (fifo_count == '0);

endmodule
